instr_fetch_responder: RTL and testbench
========================================

Name: instr_fetch_responder

Overview:
Instruction-memory responder for the PC-driven fetch path. It accepts byte addresses from the fetch initiator through a valid/ready request channel and reads a little-endian 32-bit word from a byte-addressed array. It returns the word through a valid/ready response channel backed by a 2-entry buffer. A byte-wide load port fills the array; a flush input discards in-flight responses when a branch redirects the PC.

Parameters:
ADDRESS_WIDTH, 8, byte-address width; array holds 2^ADDRESS_WIDTH bytes
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  fetch request present
req_addr  input  ADDRESS_WIDTH  byte address of instruction (PC)
req_ready  output  1  request accepted this cycle when high with req_valid
rsp_valid  output  1  response buffer head valid
rsp_ready  input  1  consumer takes head this cycle
rsp_data  output  DATA_WIDTH  instruction word at head
rsp_addr  output  ADDRESS_WIDTH  echoed request address at head
rsp_misaligned  output  1  head request had req_addr[1:0] != 0
flush  input  1  discard all buffered responses
ld_en  input  1  byte write enable
ld_addr  input  ADDRESS_WIDTH  byte write address
ld_byte  input  8  byte write data

Behaviour:
- Reset: clk and rst only. Sync, active-high. Clears the buffer: count=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_misaligned=0. Memory array is NOT cleared.
- Handshake rules:
  - req_ready = (count != 2) && !flush. Combinational from count and flush only; no path from rsp_ready.
  - Accept = req_valid && req_ready. Read occurs at the accepting edge.
  - Entry {word, addr, misaligned} is pushed at the tail. Earliest rsp_valid is the next cycle (1-cycle latency).
  - Pop = rsp_valid && rsp_ready. Head advances on the edge.
  - Simultaneous push and pop at count=1: count stays 1. The new entry becomes head after the old one leaves, preserving order.
- Word formation: rsp_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - Index arithmetic is modulo 2^ADDRESS_WIDTH; address 0xFE reads bytes FE,FF,00,01.
- Misaligned address: data is still returned per the formula above; rsp_misaligned=1 for that entry.
- Load port: ld_en writes mem[ld_addr]=ld_byte at the edge.
  - If a load and an accepted fetch touch the same byte in the same cycle, the fetch returns the OLD byte (read-before-write).
- Flush: at the edge, count becomes 0 and rsp_valid is 0 the next cycle. req_ready is low during the flush cycle, so no request is accepted. A pop in the same cycle is irrelevant.
- rst has priority over flush, load, push and pop. rst mid-stream discards all buffered entries; array contents persist.
- Buffer is a 2-entry circular FIFO with 1-bit head/tail pointers and a 2-bit count. No overflow or underflow is possible by construction.

Optional Feature:
FETCH_STATS_EN.
- Defined: adds outputs fetch_count (32, increments on each accept) and stall_count (32, increments each cycle with rsp_valid && !rsp_ready). Both saturate at 0xFFFFFFFF, clear on rst only, and are unaffected by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Load bytes 0x13,0x05,0x10,0x00 at 0x00..0x03. Request addr 0x00 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x00100513, rsp_addr=0x00, rsp_misaligned=0.
2. rsp_ready=0; requests 0x00, 0x04, 0x08 on consecutive cycles -> first two accepted, req_ready=0 at count=2, third held. Raise rsp_ready -> responses in order 0x00, 0x04, then 0x08 accepted.
3. Load 0xAA at 0xFE, 0xBB at 0xFF, 0xCC at 0x00, 0xDD at 0x01. Request 0xFE -> rsp_data=0xDDCCBBAA, rsp_misaligned=1.
4. Two entries buffered; assert flush one cycle with req_valid=1 -> req_ready=0 that cycle, rsp_valid=0 next cycle, no entry from that request appears.
5. Same cycle: ld_en at 0x04 with 0xFF (old 0x00) and accepted fetch of 0x04 -> response low byte 0x00. Refetch 0x04 -> low byte 0xFF.
6. Two entries buffered; assert rst -> rsp_valid=0, req_ready=1 next cycle, array data preserved on refetch. With FETCH_STATS_EN defined: 3 accepts and 2 stall cycles -> fetch_count=3, stall_count=2, both 0 after rst.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// ============================================================================
// instr_fetch_responder
// ----------------------------------------------------------------------------
// Instruction-memory responder for the PC-driven fetch path.
//
// A fetch initiator presents byte addresses on a valid/ready request channel.
// Each accepted address reads a little-endian 32-bit word from a byte array.
// The word is returned on a valid/ready response channel, which is backed by
// a two-entry circular buffer. A byte-wide load port fills the array. A flush
// input throws away every buffered response when a branch redirects the PC.
//
// Parameters
//   ADDRESS_WIDTH  byte-address width; the array holds 2^ADDRESS_WIDTH bytes
//   DATA_WIDTH     instruction word width; always 32 (four bytes)
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous active-high reset (clears buffer, not array)
//   req_valid       fetch request present
//   req_addr        byte address of the instruction (PC)
//   req_ready       request accepted this cycle when high with req_valid
//   rsp_valid       response buffer head is valid
//   rsp_ready       consumer takes the head this cycle
//   rsp_data        instruction word at the head
//   rsp_addr        echoed request address at the head
//   rsp_misaligned  head request had req_addr[1:0] != 0
//   flush           discard all buffered responses
//   ld_en           byte write enable for the array
//   ld_addr         byte write address
//   ld_byte         byte write data
//
// Optional build macro
//   FETCH_STATS_EN  adds the fetch_count and stall_count outputs. Both are
//                   32-bit saturating counters that clear on rst only.
//                   fetch_count counts accepted requests. stall_count counts
//                   cycles where the head is valid but the consumer holds it.
// ============================================================================
module instr_fetch_responder #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   output logic                     req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_data,
   output logic [ADDRESS_WIDTH-1:0] rsp_addr,
   output logic                     rsp_misaligned,
   input  logic                     flush,
   input  logic                     ld_en,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr,
   input  logic [7:0]               ld_byte
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]              fetch_count,
   output logic [31:0]              stall_count
`endif
);

   localparam int MEM_DEPTH = 1 << ADDRESS_WIDTH;

   // Byte-addressed instruction array. Reset does not touch it.
   logic [7:0] mem [MEM_DEPTH];

   // Two-entry response buffer, stored as parallel arrays.
   logic [DATA_WIDTH-1:0]    buf_data [2];
   logic [ADDRESS_WIDTH-1:0] buf_addr [2];
   logic                     buf_mis  [2];

   logic       head;
   logic       tail;
   logic [1:0] count;

   // Handshake qualifiers and the word fetched for the current request.
   logic                     push;
   logic                     pop;
   logic [ADDRESS_WIDTH-1:0] addr_p1;
   logic [ADDRESS_WIDTH-1:0] addr_p2;
   logic [ADDRESS_WIDTH-1:0] addr_p3;
   logic [DATA_WIDTH-1:0]    fetch_word;
   logic                     fetch_mis;

   // req_ready depends only on buffer occupancy and flush. It has no path
   // from rsp_ready, so the initiator never sees a combinational loop
   // through the consumer. A full buffer refuses even when a pop is pending.
   // The flush cycle refuses the request, so the redirected stream starts
   // clean.
   always_comb begin
      req_ready = (count != 2'd2) && !flush;
      push      = req_valid && req_ready;
      pop       = rsp_valid && rsp_ready;
   end

   // The head is valid whenever the buffer holds something. The output
   // fields come straight from the head slot. Reset zeroes both slots, so
   // these fields read zero right after reset.
   always_comb begin
      rsp_valid      = (count != 2'd0);
      rsp_data       = buf_data[head];
      rsp_addr       = buf_addr[head];
      rsp_misaligned = buf_mis[head];
   end

   // Gather the four bytes of the word. The address increments are kept at
   // ADDRESS_WIDTH bits so they wrap around the top of the array. For
   // example, a fetch at the last address pulls the following bytes from
   // address 0 and up. The read sees the array before this edge's load, so
   // a load to the same byte in the same cycle is not visible to the fetch.
   always_comb begin
      addr_p1    = req_addr + ADDRESS_WIDTH'(1);
      addr_p2    = req_addr + ADDRESS_WIDTH'(2);
      addr_p3    = req_addr + ADDRESS_WIDTH'(3);
      fetch_word = {mem[addr_p3], mem[addr_p2], mem[addr_p1], mem[req_addr]};
      fetch_mis  = (req_addr[1:0] != 2'b00);
   end

   // Array write port. It has no reset so the program survives a core
   // reset. The only effect of reset is to block a load in that same cycle.
   always_ff @(posedge clk) begin
      if (!rst && ld_en) begin
         mem[ld_addr] <= ld_byte;
      end
   end

   // Response buffer. Reset wins over everything, then flush, then the
   // normal push/pop traffic. A push while one entry is held writes the
   // other slot. The head only moves on a pop, so order is preserved. The
   // count cannot overflow or underflow: a push needs count != 2 and a pop
   // needs count != 0. So a plain increment or decrement is always safe.
   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= 2'd0;
         head        <= 1'b0;
         tail        <= 1'b0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_addr[0] <= '0;
         buf_addr[1] <= '0;
         buf_mis[0]  <= 1'b0;
         buf_mis[1]  <= 1'b0;
      end else if (flush) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) begin
            buf_data[tail] <= fetch_word;
            buf_addr[tail] <= req_addr;
            buf_mis[tail]  <= fetch_mis;
            tail           <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   // Performance counters. They saturate instead of wrapping, so a long run
   // never reports a small bogus number. They ignore flush, so a redirect
   // does not hide the fetches or stalls that happened before it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (push && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (rsp_valid && !rsp_ready && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// ============================================================================
// tb_instr_fetch_responder
// ----------------------------------------------------------------------------
// Testbench for instr_fetch_responder. A reference model runs alongside the
// DUT. The model keeps a byte array, a queue of pending responses and the
// statistic counts. Each cycle it checks the DUT's request and response
// signals against that model. Directed steps walk the main scenarios, and
// randomized traffic follows them.
// ============================================================================
module tb_instr_fetch_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [7:0]  req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [7:0]  rsp_addr;
   logic        rsp_misaligned;
   logic        flush;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [7:0]  ld_byte;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   instr_fetch_responder #(
      .ADDRESS_WIDTH(8),
      .DATA_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_addr(rsp_addr),
      .rsp_misaligned(rsp_misaligned),
      .flush(flush),
      .ld_en(ld_en),
      .ld_addr(ld_addr),
      .ld_byte(ld_byte)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count(fetch_count),
      .stall_count(stall_count)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state.
   typedef struct {
      logic [31:0] data;
      logic [7:0]  addr;
      logic        mis;
   } entryT;

   entryT       refQueue [$];
   logic [7:0]  refMem [256];
   logic [31:0] refFetch;
   logic [31:0] refStall;

   int assertCount;
   int failCount;

   // A single comparison. It counts the comparison and reports any
   // difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compare the response side of the DUT with the head of the model queue.
   task automatic checkModel(input string tag);
      checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid},
                  {31'd0, refQueue.size() != 0});
      if (refQueue.size() != 0) begin
         checkOutput({tag, " rsp_data"}, rsp_data, refQueue[0].data);
         checkOutput({tag, " rsp_addr"}, {24'd0, rsp_addr}, {24'd0, refQueue[0].addr});
         checkOutput({tag, " rsp_mis"}, {31'd0, rsp_misaligned}, {31'd0, refQueue[0].mis});
      end
`ifdef FETCH_STATS_EN
      checkOutput({tag, " fetch_count"}, fetch_count, refFetch);
      checkOutput({tag, " stall_count"}, stall_count, refStall);
`endif
   endtask

   // Drive one cycle of inputs at the falling edge, then check req_ready
   // against the model. Next, the model advances across the rising edge.
   // Last, the registered outputs are checked at the next falling edge.
   task automatic applyStimulus(input logic r, input logic f, input logic rv,
                                input logic [7:0] ra, input logic rr,
                                input logic le, input logic [7:0] la,
                                input logic [7:0] lb, input string tag);
      logic  expReady;
      logic  accept;
      entryT newEntry;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      rst       = r;
      flush     = f;
      req_valid = rv;
      req_addr  = ra;
      rsp_ready = rr;
      ld_en     = le;
      ld_addr   = la;
      ld_byte   = lb;
      #1;
      expReady = (refQueue.size() < 2) && !f;
      if (!r) begin
         checkOutput({tag, " req_ready"}, {31'd0, req_ready}, {31'd0, expReady});
      end
      accept = rv && expReady;
      a1 = ra + 8'd1;
      a2 = ra + 8'd2;
      a3 = ra + 8'd3;
      newEntry.data = {refMem[a3], refMem[a2], refMem[a1], refMem[ra]};
      newEntry.addr = ra;
      newEntry.mis  = (ra % 4) != 0;
      if (r) begin
         refQueue.delete();
         refFetch = 0;
         refStall = 0;
      end else begin
         if (refQueue.size() != 0 && !rr && refStall != 32'hFFFF_FFFF) refStall++;
         if (accept && refFetch != 32'hFFFF_FFFF) refFetch++;
         if (f) begin
            refQueue.delete();
         end else begin
            if (refQueue.size() != 0 && rr) void'(refQueue.pop_front());
            if (accept) refQueue.push_back(newEntry);
         end
         if (le) refMem[la] = lb;
      end
      @(posedge clk);
      @(negedge clk);
      checkModel(tag);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      refFetch    = 0;
      refStall    = 0;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 8'd0;
      rsp_ready = 1'b1; ld_en = 1'b0; ld_addr = 8'd0; ld_byte = 8'd0;
      @(negedge clk);

      // Reset: buffer empty, head fields zero, ready to accept.
      applyStimulus(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "reset");
      applyStimulus(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "reset");
      checkOutput("reset rsp_data zero", rsp_data, 32'd0);
      checkOutput("reset rsp_addr zero", {24'd0, rsp_addr}, 32'd0);
      checkOutput("reset rsp_mis zero", {31'd0, rsp_misaligned}, 32'd0);
      rst = 1'b0; #1;
      checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);

      // Fill the whole array with random bytes so every fetch has known data.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'(i), 8'($urandom), "preload");
      end

      // Fetch a known instruction word from address 0.
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h13, "load");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h01, 8'h05, "load");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h02, 8'h10, "load");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h03, 8'h00, "load");
      for (int i = 4; i < 12; i++) begin
         applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'(i), 8'h00, "load");
      end
      applyStimulus(0, 0, 1, 8'h00, 1, 0, 8'h00, 8'h00, "fetch0");
      checkOutput("fetch0 word", rsp_data, 32'h0010_0513);
      checkOutput("fetch0 valid", {31'd0, rsp_valid}, 32'd1);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "drain");

      // Backpressure: two entries fill the buffer and the third is held.
      applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, "bp0");
      applyStimulus(0, 0, 1, 8'h04, 0, 0, 8'h00, 8'h00, "bp4");
      applyStimulus(0, 0, 1, 8'h08, 0, 0, 8'h00, 8'h00, "bp8held");
      checkOutput("bp head addr 0", {24'd0, rsp_addr}, 32'h00);
      applyStimulus(0, 0, 1, 8'h08, 1, 0, 8'h00, 8'h00, "bp8full");
      checkOutput("bp head addr 4", {24'd0, rsp_addr}, 32'h04);
      applyStimulus(0, 0, 1, 8'h08, 1, 0, 8'h00, 8'h00, "bp8acc");
      checkOutput("bp head addr 8", {24'd0, rsp_addr}, 32'h08);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "drain");

      // Wrap-around fetch across the top of the array.
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'hFE, 8'hAA, "wrapld");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'hFF, 8'hBB, "wrapld");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'hCC, "wrapld");
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h01, 8'hDD, "wrapld");
      applyStimulus(0, 0, 1, 8'hFE, 1, 0, 8'h00, 8'h00, "wrap");
      checkOutput("wrap word", rsp_data, 32'hDDCC_BBAA);
      checkOutput("wrap misaligned", {31'd0, rsp_misaligned}, 32'd1);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "drain");

      // Flush with two entries held and a request pending.
      applyStimulus(0, 0, 1, 8'h10, 0, 0, 8'h00, 8'h00, "fl1");
      applyStimulus(0, 0, 1, 8'h14, 0, 0, 8'h00, 8'h00, "fl2");
      applyStimulus(0, 1, 1, 8'h20, 1, 0, 8'h00, 8'h00, "flush");
      checkOutput("flush empties", {31'd0, rsp_valid}, 32'd0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "postflush");

      // A load and a fetch of the same byte in one cycle: the fetch sees the
      // old byte, and a later refetch sees the new one.
      applyStimulus(0, 0, 1, 8'h04, 1, 1, 8'h04, 8'hFF, "rbw");
      checkOutput("rbw old byte", {24'd0, rsp_data[7:0]}, 32'h00);
      applyStimulus(0, 0, 1, 8'h04, 1, 0, 8'h00, 8'h00, "refetch");
      checkOutput("refetch new byte", {24'd0, rsp_data[7:0]}, 32'hFF);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "drain");

      // Reset mid-stream drops buffered entries but keeps the array.
      applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, "rs1");
      applyStimulus(0, 0, 1, 8'h04, 0, 0, 8'h00, 8'h00, "rs2");
      applyStimulus(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, "midreset");
      checkOutput("midreset valid", {31'd0, rsp_valid}, 32'd0);
      applyStimulus(0, 0, 1, 8'h04, 0, 0, 8'h00, 8'h00, "stat1");
      checkOutput("persist byte", {24'd0, rsp_data[7:0]}, 32'hFF);
      applyStimulus(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, "stat2");
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "stat3");
      applyStimulus(0, 0, 1, 8'h08, 1, 0, 8'h00, 8'h00, "stat4");
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, "stat5");
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "stat6");
`ifdef FETCH_STATS_EN
      checkOutput("stats fetch 3", fetch_count, 32'd3);
      checkOutput("stats stall 2", stall_count, 32'd2);
      applyStimulus(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, "statreset");
      checkOutput("stats fetch clr", fetch_count, 32'd0);
      checkOutput("stats stall clr", stall_count, 32'd0);
`endif

      // Randomized traffic: requests, backpressure, loads, flushes, resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 2),
                       1'($urandom_range(0, 99) < 5),
                       1'($urandom_range(0, 99) < 70),
                       8'($urandom),
                       1'($urandom_range(0, 99) < 60),
                       1'($urandom_range(0, 99) < 30),
                       8'($urandom),
                       8'($urandom),
                       "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
